// File: rtl/sumador_pipe.sv
// Carry-pipelined two-operand adder: WIDTH/CHUNK registered carry stages, valid/ready on
// both sides, and an optional per-transaction gate that forces a qualified zero result.
module sumador_pipe #(
  parameter int              WIDTH  = 8,
  parameter int              CHUNK  = 4,
  parameter logic [WIDTH-1:0] THRESH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   o1,
  output logic             o1_en
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole pipe
  // moves as one (advance) whenever the output slot is empty or being taken this cycle.
  logic advance;

  // Stage registers: stage k holds the sum of chunks 0..k, the carry out of chunk k,
  // and the untouched operands for the chunks still to come.
  logic             v_q [STAGES];
  logic             g_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];

  logic             v_s [STAGES];
  logic             g_s [STAGES];
  logic             c_s [STAGES];
  logic [WIDTH-1:0] a_s [STAGES];
  logic [WIDTH-1:0] b_s [STAGES];
  logic [WIDTH-1:0] s_s [STAGES];

  logic             v_d [STAGES];
  logic             g_d [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  logic [CHUNK:0]   part;

  always_comb begin
    part   = '0;
    v_s[0] = in_valid;
    g_s[0] = mode && (i1 <= THRESH);
    c_s[0] = 1'b0;
    a_s[0] = i1;
    b_s[0] = i2;
    s_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_s[k] = v_q[k-1];
      g_s[k] = g_q[k-1];
      c_s[k] = c_q[k-1];
      a_s[k] = a_q[k-1];
      b_s[k] = b_q[k-1];
      s_s[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      part   = {1'b0, a_s[k][k*CHUNK +: CHUNK]}
             + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, c_s[k]};
      v_d[k] = v_s[k];
      g_d[k] = g_s[k];
      a_d[k] = a_s[k];
      b_d[k] = b_s[k];
      s_d[k] = s_s[k];
      s_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k] = part[CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        g_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        g_q[k] <= g_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  // Every operand chunk has been consumed by the time it reaches the last stage.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[LAST], b_q[LAST]};

  assign out_valid = v_q[LAST];
  assign o1_en     = v_q[LAST] && !g_q[LAST];
  assign o1        = o1_en ? {c_q[LAST], s_q[LAST]} : '0;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && rst_n;

endmodule
